// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage enabled register pipeline with per-stage valid bits,
// flush, occupancy counter and a combinational tap read of any stage.
module dff_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned TW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [TW-1:0]    tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [WIDTH-1:0] tap_q,
  output logic [CW-1:0]    fill_count,
  output logic             empty
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_tap;

  // Occupancy after an enabled edge: one item may enter and one may leave.
  always_comb begin
    w_count_nxt = r_count + CW'(d_valid) - CW'(r_valid[DEPTH-1]);
  end

  // Data path: reset dominates flush, flush dominates shifting; flush keeps data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
    end else if (!flush && en) begin
      r_data[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
      end
    end
  end

  // Valid bits and occupancy counter share the same priority as the data path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (en) begin
      r_valid[0] <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
      r_count <= w_count_nxt;
    end
  end

  // Tap read; an out-of-range stage index reads as zero.
  always_comb begin
    w_tap = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TW'(i)) begin
        w_tap = r_data[i];
      end
    end
  end

  assign q          = r_data[DEPTH-1];
  assign q_valid    = r_valid[DEPTH-1];
  assign tap_q      = w_tap;
  assign fill_count = r_count;
  assign empty      = (r_count == '0);

endmodule
